// File: rtl/sparse_pkg.sv
// Shared constants, state encoding and lane helpers for the sparse index sequencer.
// The optional SPARSE_ACT_SKIP_EN build uses act_nonzero() to drop zero-activation lanes.
package sparse_pkg;

    localparam int LANES = 4;
    localparam int DBITS = 4;
    localparam int IDXW  = 2;
    localparam int WORDW = LANES * DBITS;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // One bit per lane, set where that lane's activation is nonzero.
    function automatic logic [LANES-1:0] act_nonzero(input logic [WORDW-1:0] act);
        logic [LANES-1:0] nz;
        nz = '0;
        for (int k = 0; k < LANES; k++) begin
            nz[k] = (act[k*DBITS +: DBITS] != '0);
        end
        return nz;
    endfunction

endpackage

// File: rtl/lsb_prienc_4.sv
// Lowest-set-bit encoder for a 4-lane mask: index, isolated onehot, and a flag
// that is high when exactly one bit of the input is set.
module lsb_prienc_4
    import sparse_pkg::*;
(
    input  logic [LANES-1:0] vec,
    output logic [IDXW-1:0]  idx,
    output logic [LANES-1:0] onehot,
    output logic             last
);

    always_comb begin
        onehot = vec & (~vec + 4'd1);
        last   = (vec != '0) && ((vec & (vec - 4'd1)) == '0);
        idx    = '0;
        // Scan high-to-low so the lowest set lane wins.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/sparse_idx_seq.sv
// Accepts 4-lane groups and emits one beat per effective nonzero lane, lowest lane first.
// Define SPARSE_ACT_SKIP_EN to also skip lanes whose activation is zero.
module sparse_idx_seq
    import sparse_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] in_mask,
    input  logic [WORDW-1:0] in_act,
    input  logic [WORDW-1:0] in_wgt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WORDW-1:0] out_act,
    output logic [IDXW-1:0]  out_idx,
    output logic [DBITS-1:0] out_wgt,
    output logic             out_last,
    output logic             out_empty,
    output logic [15:0]      stat_groups
);

    state_e           state_q, state_d;
    logic [LANES-1:0] rem_q, rem_d;
    logic [WORDW-1:0] act_q, act_d;
    logic [WORDW-1:0] wgt_q, wgt_d;
    logic [15:0]      stat_q, stat_d;

    logic [LANES-1:0] eff_mask;
    logic [LANES-1:0] onehot;
    logic [IDXW-1:0]  idx;
    logic             one_left;
    logic             scan;
    logic             rem_zero;
    logic             beat;
    logic             accept;

`ifdef SPARSE_ACT_SKIP_EN
    assign eff_mask = in_mask & act_nonzero(in_act);
`else
    assign eff_mask = in_mask;
`endif

    lsb_prienc_4 u_prienc (
        .vec    (rem_q),
        .idx    (idx),
        .onehot (onehot),
        .last   (one_left)
    );

    always_comb begin
        scan     = (state_q == SCAN);
        rem_zero = (rem_q == '0);

        // An empty rem while scanning is the single empty beat of an all-zero group.
        out_valid = scan;
        out_act   = act_q;
        out_idx   = idx;
        out_wgt   = rem_zero ? '0 : wgt_q[int'(idx)*DBITS +: DBITS];
        out_last  = scan & (one_left | rem_zero);
        out_empty = scan & rem_zero;

        in_ready = ~scan | (out_last & out_ready);
        beat     = scan & out_ready;
        accept   = in_valid & in_ready;

        state_d = state_q;
        rem_d   = rem_q;
        act_d   = act_q;
        wgt_d   = wgt_q;
        stat_d  = stat_q;

        if (beat) begin
            rem_d = rem_q & ~onehot;
            if (out_last) begin
                state_d = IDLE;
                if (stat_q != 16'hFFFF) begin
                    stat_d = stat_q + 16'd1;
                end
            end
        end

        // A new group accepted on the last beat overrides the return to IDLE.
        if (accept) begin
            state_d = SCAN;
            rem_d   = eff_mask;
            act_d   = in_act;
            wgt_d   = in_wgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            act_q   <= '0;
            wgt_q   <= '0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            act_q   <= act_d;
            wgt_q   <= wgt_d;
            stat_q  <= stat_d;
        end
    end

    assign stat_groups = stat_q;

endmodule

// File: tb/tb_sparse_idx_seq.sv
// Self-checking bench for sparse_idx_seq: directed scenarios then random traffic,
// compared against a beat-list reference model built from the lane rules.
module tb_sparse_idx_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_mask;
    logic [15:0] in_act;
    logic [15:0] in_wgt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_act;
    logic [1:0]  out_idx;
    logic [3:0]  out_wgt;
    logic        out_last;
    logic        out_empty;
    logic [15:0] stat_groups;

    always #5 clk = ~clk;

    sparse_idx_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mask     (in_mask),
        .in_act      (in_act),
        .in_wgt      (in_wgt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_act     (out_act),
        .out_idx     (out_idx),
        .out_wgt     (out_wgt),
        .out_last    (out_last),
        .out_empty   (out_empty),
        .stat_groups (stat_groups)
    );

    typedef struct {
        int          idx;
        int          wgt;
        bit          last;
        bit          empty;
        logic [15:0] act;
    } beat_t;

    beat_t q[$];
    int    exp_stat = 0;
    int    ncmp = 0;
    int    nfail = 0;
    bit    rnd_ready = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beats of a group: every effective lane in ascending order, or one empty beat.
    task automatic push_group(input logic [3:0] mask, input logic [15:0] act, input logic [15:0] wgt);
        int    lanes[$];
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            bit use_lane;
            use_lane = mask[k];
`ifdef SPARSE_ACT_SKIP_EN
            if (act[k*4 +: 4] == 4'd0) use_lane = 0;
`endif
            if (use_lane) lanes.push_back(k);
        end
        if (lanes.size() == 0) begin
            b.idx = 0; b.wgt = 0; b.last = 1; b.empty = 1; b.act = act;
            q.push_back(b);
        end else begin
            for (int i = 0; i < lanes.size(); i++) begin
                b.idx   = lanes[i];
                b.wgt   = int'(wgt[lanes[i]*4 +: 4]);
                b.last  = (i == lanes.size() - 1);
                b.empty = 0;
                b.act   = act;
                q.push_back(b);
            end
        end
    endtask

    task automatic step(output bit acc);
        bit    exp_v, exp_r;
        beat_t h;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        exp_v = (q.size() != 0);
        exp_r = (q.size() == 0) || (q.size() == 1 && out_ready);
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        chk("in_ready", 32'(in_ready), 32'(exp_r));
        chk("stat_groups", 32'(stat_groups), 32'(exp_stat));
        if (exp_v) begin
            h = q[0];
            chk("out_idx", 32'(out_idx), 32'(h.idx));
            chk("out_wgt", 32'(out_wgt), 32'(h.wgt));
            chk("out_last", 32'(out_last), 32'(h.last));
            chk("out_empty", 32'(out_empty), 32'(h.empty));
            chk("out_act", 32'(out_act), 32'(h.act));
        end
        acc = 0;
        if (rst) begin
            q.delete();
            exp_stat = 0;
        end else begin
            if (exp_v && out_ready) begin
                if (h.last && exp_stat != 65535) exp_stat++;
                void'(q.pop_front());
            end
            if (in_valid && exp_r) begin
                acc = 1;
                push_group(in_mask, in_act, in_wgt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] mask, input logic [15:0] act, input logic [15:0] wgt);
        bit got;
        got = 0;
        in_mask  = mask;
        in_act   = act;
        in_wgt   = wgt;
        in_valid = 1'b1;
        for (int i = 0; i < 64 && !got; i++) step(got);
        in_valid = 1'b0;
        if (!got) begin
            ncmp++;
            nfail++;
            $error("FAIL accept_timeout observed=not_accepted expected=accepted mask=%0h", mask);
        end
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 200 && q.size() != 0; i++) step(a);
        if (q.size() != 0) begin
            ncmp++;
            nfail++;
            $error("FAIL drain_timeout observed=%0d_beats_left expected=0", q.size());
        end
        step(a);
    endtask

    initial begin
        bit a;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mask   = '0;
        in_act    = '0;
        in_wgt    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_out_wgt", 32'(out_wgt), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_empty", 32'(out_empty), 0);
        chk("rst_out_act", 32'(out_act), 0);
        chk("rst_stat", 32'(stat_groups), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two lanes of four
        send(4'b1010, 16'h1111, {4'd9, 4'd7, 4'd5, 4'd3});
        drain();
        chk("stat_after_1010", 32'(stat_groups), 1);

        // All-zero mask gives one empty beat
        send(4'b0000, 16'h2222, 16'h1234);
        drain();

        // Stall on the second beat
        send(4'b1111, 16'h1111, 16'hABCD);
        step(a);
        out_ready = 1'b0;
        repeat (3) step(a);
        out_ready = 1'b1;
        drain();

        // Back-to-back groups with no bubble
        send(4'b0001, 16'h5555, 16'h0006);
        send(4'b0110, 16'h6666, 16'h0870);
        drain();

        // Zero activation on lane 2
        send(4'b1111, 16'h1023, 16'h4321);
        drain();

        // Reset after first of three beats
        send(4'b0111, 16'h1111, 16'h0321);
        step(a);
        rst = 1'b1;
        step(a);
        rst = 1'b0;
        step(a);
        chk("stat_after_rst", 32'(stat_groups), 0);

        // Random traffic with random backpressure
        rnd_ready = 1;
        for (int g = 0; g < 60; g++) begin
            if ($urandom_range(0, 3) == 0) step(a);
            send(4'($urandom), 16'($urandom), 16'($urandom));
        end
        drain();
        rnd_ready = 0;
        out_ready = 1'b1;
        step(a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/sparse_idx_seq.md
SPARSE_IDX_SEQ -- requirements
Module: sparse_idx_seq

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1  upstream group valid.
REQ-004 in_ready  out  1  group accepted when in_valid & in_ready.
REQ-005 in_mask  in  4  weight nonzero bitmask, bit k = lane k.
REQ-006 in_act  in  16  four 4-bit activations; lane k at bits [4k+3:4k].
REQ-007 in_wgt  in  16  four 4-bit weights; same packing.
REQ-008 out_valid  out  1  beat valid.
REQ-009 out_ready  in  1  beat consumed when out_valid & out_ready.
REQ-010 out_act  out  16  registered activation word of the current group, fed to the 4:1 lane selector.
REQ-011 out_idx  out  2  lane index of the current nonzero lane.
REQ-012 out_wgt  out  4  weight of lane out_idx.
REQ-013 out_last  out  1  final beat of the group.
REQ-014 out_empty  out  1  group had no effective nonzero lane.
REQ-015 stat_groups  out  16  count of completed groups, saturating.

Function
REQ-016 States: IDLE, SCAN; a rem[3:0] register holds the lanes not yet emitted.
REQ-017 IDLE: in_ready=1, out_valid=0; on accept, latch act, wgt and effective mask into rem; go to SCAN.
REQ-018 SCAN: out_valid=1; out_idx = lowest set bit of rem; out_wgt = wgt lane out_idx.
REQ-019 On a beat handshake, clear bit out_idx in rem; out_last=1 when rem has exactly one bit set.
REQ-020 Zero effective mask: emit one beat with out_idx=0, out_wgt=0, out_last=1, out_empty=1.
REQ-021 out_act, out_idx, out_wgt and out_last stay stable while out_valid=1 and out_ready=0.
REQ-022 Latency: first beat valid on the cycle after accept; one beat per cycle while out_ready=1.
REQ-023 in_ready = IDLE | (SCAN & out_last & out_ready); a back-to-back accept loads the new group and stays in SCAN with no bubble.
REQ-024 Last-beat handshake with no new accept: return to IDLE.
REQ-025 Group of N effective lanes yields max(N,1) beats in ascending lane order.
REQ-026 stat_groups increments on each last-beat handshake and saturates at 16'hFFFF.

Reset
REQ-027 On rst: state=IDLE; rem, out_act, out_idx, out_wgt, out_last, out_empty and stat_groups = 0; out_valid=0.
REQ-028 Reset mid-group discards the group; the next cycle has in_ready=1 and out_valid=0.
REQ-029 rst has priority over any simultaneous handshake.

Configuration
REQ-030 Macro SPARSE_ACT_SKIP_EN defined: effective mask = in_mask & per-lane (activation != 0).
REQ-031 Macro SPARSE_ACT_SKIP_EN undefined: effective mask = in_mask.

Structure
REQ-032 Shared package sparse_pkg holds LANES=4, DBITS=4, IDXW=2, the state enum, and the lane-packing width constants.
REQ-033 Sub-module lsb_prienc_4: combinational lowest-set-bit encoder producing a 2-bit index plus onehot and last flags.

Verification
REQ-034 mask=4'b1010, wgt lanes=3,5,7,9, out_ready=1 -> two beats: (idx=1, wgt=5, last=0), then (idx=3, wgt=9, last=1); stat_groups=1.
REQ-035 mask=4'b0000 -> one beat: idx=0, wgt=0, last=1, empty=1.
REQ-036 mask=4'b1111 with out_ready low for 3 cycles at beat 2 -> idx=1 held stable; total 4 beats, order 0,1,2,3.
REQ-037 Two groups back-to-back (mask 4'b0001, then 4'b0110) -> in_ready=1 on the last beat; beats idx 0, 1, 2 on consecutive cycles.
REQ-038 With SPARSE_ACT_SKIP_EN: mask=4'b1111, act lane 2=0 -> beats idx 0, 1, 3; without the macro: 0, 1, 2, 3.
REQ-039 rst asserted after the first of three beats -> next cycle out_valid=0 and in_ready=1; stat_groups=0.
